// File: rtl/counter_pkg.sv
// Shared types and defaults for the LED counter run-control logic.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } ctrl_state_t;

   localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/counter_ctrl_tick_gen.sv
// Prescaler for the run-control sequencer: one tick every PRESCALE enabled cycles.
module tick_gen #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic tick
);

   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_pre;

   // clr dominates run so a restart or a move to IDLE/DONE always lands on 0
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         r_pre <= '0;
      end else if (run) begin
         if (r_pre == LAST) r_pre <= '0;
         else               r_pre <= r_pre + 1'b1;
      end
   end

   assign tick = (r_pre == LAST);

endmodule

// File: rtl/counter_ctrl.sv
// Run-control sequencer: turns start/stop/pause pulses into paced enable and clear strobes.
module counter_ctrl
   import counter_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int PRESCALE = 125_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode_reload,
   input  logic [CNT_W-1:0] limit,
   input  logic [CNT_W-1:0] count_in,
   output logic             cnt_en,
   output logic             cnt_clr,
   output logic             busy,
   output logic             done,
   output logic [1:0]       state_o
);

   ctrl_state_t      r_state;
   ctrl_state_t      w_state_nxt;
   logic [CNT_W-1:0] r_limit;
   logic             r_cnt_en;
   logic             r_cnt_clr;
   logic             r_busy;
   logic             r_done;

   logic w_en_nxt;
   logic w_clr_nxt;
   logic w_start_acc;
   logic w_pre_tick;
   logic w_tick;
   logic w_pre_run;
   logic w_pre_clr;

   assign w_tick = (r_state == RUN) && w_pre_tick;

   always_comb begin
      w_state_nxt = r_state;
      w_en_nxt    = 1'b0;
      w_clr_nxt   = 1'b0;
      w_start_acc = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_start_acc = 1'b1;
               w_clr_nxt   = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               w_clr_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end else if (start) begin
               w_start_acc = 1'b1;
               w_clr_nxt   = 1'b1;
               w_state_nxt = RUN;
            end else begin
               if (pause) w_state_nxt = PAUSE;
               // reaching the one-shot limit overrides a coincident pause
               if (w_tick) begin
                  if (count_in != r_limit) w_en_nxt    = 1'b1;
                  else if (mode_reload)    w_clr_nxt   = 1'b1;
                  else                     w_state_nxt = DONE;
               end
            end
         end
         PAUSE: begin
            if (stop) begin
               w_clr_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end else if (start) begin
               w_start_acc = 1'b1;
               w_clr_nxt   = 1'b1;
               w_state_nxt = RUN;
            end else if (pause) begin
               w_state_nxt = RUN;
            end
         end
         DONE: begin
            if (stop) begin
               w_clr_nxt   = 1'b1;
               w_state_nxt = IDLE;
            end else if (start) begin
               w_start_acc = 1'b1;
               w_clr_nxt   = 1'b1;
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // prescaler freezes on entry to PAUSE unless that cycle also carries a tick
   assign w_pre_run = (r_state == RUN) && ((w_state_nxt != PAUSE) || w_tick);
   assign w_pre_clr = w_start_acc || (w_state_nxt == IDLE) || (w_state_nxt == DONE);

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .run  (w_pre_run),
      .clr  (w_pre_clr),
      .tick (w_pre_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_limit   <= '0;
         r_cnt_en  <= 1'b0;
         r_cnt_clr <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt_en  <= w_en_nxt;
         r_cnt_clr <= w_clr_nxt;
         r_busy    <= (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
         r_done    <= (w_state_nxt == DONE);
         if (w_start_acc) r_limit <= limit;
      end
   end

   assign cnt_en  = r_cnt_en;
   assign cnt_clr = r_cnt_clr;
   assign busy    = r_busy;
   assign done    = r_done;
   assign state_o = r_state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with PRESCALE=4, driving a behavioural 4-bit counter.
module tb_counter_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       pause;
   logic       mode_reload;
   logic [3:0] limit;
   logic [3:0] count_in;
   logic       cnt_en;
   logic       cnt_clr;
   logic       busy;
   logic       done;
   logic [1:0] state_o;

   int n_chk = 0;
   int n_err = 0;
   int n_en  = 0;
   int n_clr = 0;
   int n_both = 0;
   int snap_en;
   int snap_clr;

   logic [3:0] r_cnt;

   always #5 clk = ~clk;

   counter_ctrl #(
      .CNT_W    (4),
      .PRESCALE (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .pause       (pause),
      .mode_reload (mode_reload),
      .limit       (limit),
      .count_in    (count_in),
      .cnt_en      (cnt_en),
      .cnt_clr     (cnt_clr),
      .busy        (busy),
      .done        (done),
      .state_o     (state_o)
   );

   // counter datapath stand-in: updates one cycle after a strobe
   always @(posedge clk) begin
      if (!rst)         r_cnt <= 4'd0;
      else if (cnt_clr) r_cnt <= 4'd0;
      else if (cnt_en)  r_cnt <= r_cnt + 4'd1;
      if (cnt_en)  n_en  <= n_en + 1;
      if (cnt_clr) n_clr <= n_clr + 1;
      if (cnt_en && cnt_clr) n_both <= n_both + 1;
   end
   assign count_in = r_cnt;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; step(1); start = 1'b0;
   endtask
   task automatic pulse_stop();
      stop = 1'b1; step(1); stop = 1'b0;
   endtask
   task automatic pulse_pause();
      pause = 1'b1; step(1); pause = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
      mode_reload = 1'b0; limit = 4'd0;
      step(2);
      chk("rst_state", 32'(state_o), 0);
      chk("rst_en",    32'(cnt_en),  0);
      chk("rst_clr",   32'(cnt_clr), 0);
      chk("rst_busy",  32'(busy),    0);
      chk("rst_done",  32'(done),    0);
      rst = 1'b1;
      step(1);

      // one-shot to limit 3
      limit = 4'd3; mode_reload = 1'b0;
      pulse_start();
      snap_en = n_en;
      chk("os_clr",   32'(cnt_clr), 1);
      chk("os_state", 32'(state_o), 1);
      chk("os_busy",  32'(busy),    1);
      step(3);
      chk("os_no_en_early", 32'(cnt_en), 0);
      step(1);
      chk("os_first_en", 32'(cnt_en), 1);
      step(12);
      chk("os_done",     32'(done),    1);
      chk("os_busy_lo",  32'(busy),    0);
      chk("os_state_dn", 32'(state_o), 3);
      chk("os_count",    32'(r_cnt),   3);
      chk("os_en_total", 32'(n_en - snap_en), 3);
      step(8);
      chk("os_en_after", 32'(n_en - snap_en), 3);
      chk("os_done_hold", 32'(done), 1);

      // stop from DONE
      pulse_stop();
      chk("dn_stop_state", 32'(state_o), 0);
      chk("dn_stop_clr",   32'(cnt_clr), 1);
      chk("dn_stop_done",  32'(done),    0);

      // reload to limit 2; limit change mid-run must be ignored
      limit = 4'd2; mode_reload = 1'b1;
      pulse_start();
      limit = 4'd9;
      step(1);
      snap_en = n_en; snap_clr = n_clr;
      step(48);
      chk("rl_en_cnt",  32'(n_en - snap_en),   8);
      chk("rl_clr_cnt", 32'(n_clr - snap_clr), 4);
      chk("rl_count",   32'(r_cnt), 0);
      chk("rl_done",    32'(done),  0);
      chk("rl_busy",    32'(busy),  1);

      // pause at count=1, prescaler=2
      pulse_stop();
      limit = 4'd5; mode_reload = 1'b0;
      pulse_start();
      step(6);
      chk("pa_count", 32'(r_cnt), 1);
      pulse_pause();
      snap_en = n_en;
      chk("pa_state", 32'(state_o), 2);
      chk("pa_busy",  32'(busy),    1);
      step(10);
      pulse_pause();
      chk("pa_no_en",   32'(n_en - snap_en), 0);
      chk("pa_resume",  32'(state_o), 1);
      chk("pa_en_r0",   32'(cnt_en),  0);
      step(1);
      chk("pa_en_r1",   32'(cnt_en),  0);
      step(1);
      chk("pa_en_r2",   32'(cnt_en),  1);

      // stop on a tick cycle
      step(3);
      pulse_stop();
      chk("st_tick_en",    32'(cnt_en),  0);
      chk("st_tick_clr",   32'(cnt_clr), 1);
      chk("st_tick_state", 32'(state_o), 0);
      chk("st_tick_busy",  32'(busy),    0);

      // stop and start together
      pulse_start();
      step(2);
      stop = 1'b1; start = 1'b1;
      step(1);
      stop = 1'b0; start = 1'b0;
      chk("col_state", 32'(state_o), 0);
      chk("col_clr",   32'(cnt_clr), 1);
      chk("col_busy",  32'(busy),    0);
      step(1);
      chk("col_clr_once", 32'(cnt_clr), 0);
      pulse_pause();
      chk("idle_pause_ign", 32'(state_o), 0);

      // reset mid-run at count=2
      pulse_start();
      step(9);
      chk("mr_count", 32'(r_cnt), 2);
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      chk("mr_state", 32'(state_o), 0);
      chk("mr_en",    32'(cnt_en),  0);
      chk("mr_clr",   32'(cnt_clr), 0);
      chk("mr_busy",  32'(busy),    0);
      chk("mr_done",  32'(done),    0);
      pulse_start();
      chk("mr_restart_clr", 32'(cnt_clr), 1);
      step(4);
      chk("mr_restart_en", 32'(cnt_en), 1);
      step(1);
      chk("mr_restart_cnt", 32'(r_cnt), 1);

      // limit 0 one-shot: DONE on the first tick
      pulse_stop();
      limit = 4'd0; mode_reload = 1'b0;
      pulse_start();
      step(4);
      chk("l0_done",  32'(done),    1);
      chk("l0_state", 32'(state_o), 3);
      chk("l0_en",    32'(cnt_en),  0);

      // restart from DONE in reload mode with limit 0: clear on every tick
      mode_reload = 1'b1;
      pulse_start();
      chk("l0r_state", 32'(state_o), 1);
      chk("l0r_done",  32'(done),    0);
      chk("l0r_clr0",  32'(cnt_clr), 1);
      step(4);
      chk("l0r_clr1",  32'(cnt_clr), 1);
      chk("l0r_en1",   32'(cnt_en),  0);
      step(4);
      chk("l0r_clr2",  32'(cnt_clr), 1);

      chk("never_both", 32'(n_both), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
